// File: rtl/cdc_fifo_read_stream.sv
// cdc_fifo_read_stream: drains a cdc_fifo read port into a 2-entry valid/ready output stream
module cdc_fifo_read_stream #(
    parameter int DATA_WIDTH  = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   read_clock,
    input  logic                   read_reset,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_read_data,
    output logic                   read_increment,
    input  logic                   enable,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [1:0]             occupancy,
    output logic [COUNT_WIDTH-1:0] word_count
);
    logic [1:0]             r_occ;
    logic [DATA_WIDTH-1:0]  r_head;
    logic [DATA_WIDTH-1:0]  r_skid;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   w_pop;
    logic                   w_take;
    // pop depends only on registered occupancy and FIFO state, never on out_ready
    always_comb begin
        w_pop  = !read_reset && enable && !flush && !fifo_empty && (r_occ != 2'd2);
        w_take = (r_occ != 2'd0) && out_ready;
    end
    assign read_increment = w_pop;
    assign out_valid      = (r_occ != 2'd0);
    assign out_data       = r_head;
    assign occupancy      = r_occ;
    assign word_count     = r_count;
    // ordered {head, skid} buffer update; flush overrides pop/take but a take still counts
    always_ff @(posedge read_clock) begin
        if (read_reset) begin
            r_occ   <= 2'd0;
            r_head  <= '0;
            r_skid  <= '0;
            r_count <= '0;
        end else begin
            if (w_take) r_count <= r_count + 1'b1;
            if (flush) begin
                r_occ <= 2'd0;
            end else if (r_occ == 2'd0) begin
                if (w_pop) begin
                    r_head <= fifo_read_data;
                    r_occ  <= 2'd1;
                end
            end else if (r_occ == 2'd1) begin
                if (w_pop && w_take) begin
                    r_head <= fifo_read_data;
                end else if (w_pop) begin
                    r_skid <= fifo_read_data;
                    r_occ  <= 2'd2;
                end else if (w_take) begin
                    r_occ <= 2'd0;
                end
            end else if (w_take) begin
                r_head <= r_skid;
                r_occ  <= 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_cdc_fifo_read_stream.sv
// tb_cdc_fifo_read_stream: queue-model checks of the FIFO read stream adapter
module tb_cdc_fifo_read_stream;
    logic       clk = 0;
    logic       read_reset = 1;
    logic       fifo_empty = 1;
    logic [3:0] fifo_read_data = '0;
    logic       read_increment;
    logic       enable = 1;
    logic       flush = 0;
    logic       out_valid;
    logic       out_ready = 1;
    logic [3:0] out_data;
    logic [1:0] occupancy;
    logic [7:0] word_count;

    int         checks = 0;
    int         failures = 0;
    int         npops = 0;
    logic       gap = 0;
    logic [3:0] fq[$];
    logic [3:0] bq[$];
    logic [7:0] cnt = 0;

    cdc_fifo_read_stream #(.DATA_WIDTH(4), .COUNT_WIDTH(8)) dut (
        .read_clock(clk), .read_reset(read_reset), .fifo_empty(fifo_empty),
        .fifo_read_data(fifo_read_data), .read_increment(read_increment),
        .enable(enable), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .occupancy(occupancy), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        logic exp_pop;
        logic take;
        fifo_empty     = (fq.size() == 0) || gap;
        fifo_read_data = fifo_empty ? 4'($urandom) : fq[0];
        #1;
        exp_pop = !read_reset && enable && !flush && !fifo_empty && (bq.size() < 2);
        chk("rd_inc", 32'(read_increment), 32'(exp_pop));
        chk("valid", 32'(out_valid), 32'(bq.size() != 0));
        if (bq.size() != 0) chk("data", 32'(out_data), 32'(bq[0]));
        chk("occ", 32'(occupancy), 32'(bq.size()));
        chk("count", 32'(word_count), 32'(cnt));
        if (read_reset) begin
            bq.delete();
            cnt = 0;
        end else begin
            take = (bq.size() != 0) && out_ready;
            if (take) cnt++;
            if (flush) bq.delete();
            else begin
                if (take) void'(bq.pop_front());
                if (exp_pop) bq.push_back(fq.pop_front());
            end
        end
        if (exp_pop) npops++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((fq.size() != 0 || bq.size() != 0) && n < limit) begin
            step();
            n++;
        end
        chk("drain", 32'(fq.size() + bq.size()), 0);
    endtask

    initial begin
        // reset with a non-empty FIFO
        fq.push_back(4'h9);
        fifo_empty = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step();
        step();
        fq.delete();
        read_reset = 0;
        // straight stream of 1..8
        for (int i = 1; i <= 8; i++) fq.push_back(4'(i));
        npops = 0;
        repeat (8) step();
        chk("stream_pops", 32'(npops), 8);
        step();
        chk("stream_cnt", 32'(word_count), 8);
        chk("stream_occ", 32'(occupancy), 0);
        // backpressure
        out_ready = 0;
        fq.push_back(4'hA); fq.push_back(4'hB); fq.push_back(4'hC);
        npops = 0;
        repeat (4) step();
        chk("bp_pops", 32'(npops), 2);
        chk("bp_occ", 32'(occupancy), 2);
        chk("bp_data", 32'(out_data), 32'hA);
        out_ready = 1;
        step();
        chk("bp_nopop", 32'(npops), 2);
        step();
        chk("bp_pop3", 32'(npops), 3);
        drain(20);
        // flush from a full buffer
        out_ready = 0;
        fq.push_back(4'h3); fq.push_back(4'h4);
        repeat (3) step();
        chk("fl_occ2", 32'(occupancy), 2);
        fq.push_back(4'h5);
        npops = 0;
        flush = 1;
        step();
        flush = 0;
        chk("fl_nopop", 32'(npops), 0);
        chk("fl_occ0", 32'(occupancy), 0);
        chk("fl_cnt", 32'(word_count), 11);
        out_ready = 1;
        step();
        chk("fl_next", 32'(out_data), 32'h5);
        drain(20);
        // 257 words with an enable gap: counter wraps to 1
        read_reset = 1;
        step();
        read_reset = 0;
        for (int i = 0; i < 257; i++) fq.push_back(4'(i));
        for (int i = 0; i < 120; i++) begin
            enable = !(i >= 100 && i < 104);
            step();
        end
        enable = 1;
        drain(400);
        chk("wrap_cnt", 32'(word_count), 1);
        // randomized gaps, stalls, enable drops and flushes
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2) == 0 && fq.size() < 8) fq.push_back(4'($urandom));
            gap       = ($urandom_range(3) == 0);
            out_ready = ($urandom_range(2) != 0);
            enable    = ($urandom_range(7) != 0);
            flush     = ($urandom_range(39) == 0);
            step();
        end
        gap = 0; out_ready = 1; enable = 1; flush = 0;
        drain(40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
